sec_loc_decoder_arbiter: RTL

- Shares one clocked SEC location decoder (32-bit W in, found/N out) among NREQ requesters.
- Picks a requester round-robin, latches its codeword and drives it to the decoder with a start pulse.
- Waits for found, then returns N, tagged with the requester index, over a valid/ready response port.
- Sits between the codeword sources and the single decoder instance, which is too large to replicate per requester.

---
 rtl/sec_loc_decoder_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sec_loc_decoder_arbiter.sv
// sec_loc_decoder_arbiter
// Round-robin front end that shares one clocked SEC location decoder among
// NREQ codeword sources. A granted codeword is registered onto dec_w and
// launched with a one-cycle dec_start pulse. The location returned on dec_n
// goes back over a valid/ready response port, tagged with the requester index.
//
// Optional build macro: SECARB_TIMEOUT_EN
//   When it is defined, a WAIT watchdog aborts a job after MAX_WAIT cycles.
//   The aborted job answers with rsp_err = 1 and rsp_n = all ones.
//   When it is undefined, WAIT lasts until dec_found and rsp_err is constant 0.
module sec_loc_decoder_arbiter #(
  parameter int NREQ     = 4,
  parameter int W_BITS   = 32,
  parameter int N_BITS   = 25,
  parameter int MAX_WAIT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W_BITS-1:0]   req_w,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [N_BITS-1:0]        rsp_n,
  output logic                     rsp_err,
  output logic                     dec_start,
  output logic [W_BITS-1:0]        dec_w,
  input  logic                     dec_found,
  input  logic [N_BITS-1:0]        dec_n,
  output logic                     busy
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;   // last requester served
  logic [ID_W-1:0]   grant_reg;    // requester owning the current job
  logic [ID_W-1:0]   grant_idx;    // combinational round-robin winner
  logic              grant_hit;    // some requester is asking

  // Unpack the flat codeword bus so each requester's word can be indexed.
  logic [W_BITS-1:0] req_w_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_w_arr[gi] = req_w[gi*W_BITS +: W_BITS];
    end
  endgenerate

  // Search starts one past the last winner and wraps modulo NREQ. The first
  // requester found with req_valid set wins.
  always_comb begin
    logic [ID_W:0] cand;
    grant_idx = '0;
    grant_hit = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end
      if (!grant_hit && req_valid[cand[ID_W-1:0]]) begin
        grant_hit = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  // Accept is offered only in IDLE, and only to the round-robin winner.
  always_comb begin
    req_ready = '0;
    if (state_reg == S_IDLE && grant_hit) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

`ifdef SECARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt_reg;  // WAIT cycles spent on the current job
`else
  // No watchdog in this build, so the error flag is permanently low.
  // MAX_WAIT is referenced only so that it is not an unused parameter; the
  // comparison is false for every legal configuration.
  assign rsp_err = (MAX_WAIT < 0);
`endif

  // Main controller: state, round-robin pointer and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      rr_ptr_reg   <= ID_W'(NREQ-1);
      grant_reg    <= '0;
      dec_w        <= '0;
      dec_start    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_n        <= '0;
      rsp_id       <= '0;
      busy         <= 1'b0;
`ifdef SECARB_TIMEOUT_EN
      rsp_err      <= 1'b0;
      wait_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_hit) begin
            dec_w     <= req_w_arr[grant_idx];
            grant_reg <= grant_idx;
            dec_start <= 1'b1;
            busy      <= 1'b1;
            state_reg <= S_LAUNCH;
          end
        end

        // dec_found may still carry the previous job's result here, so it is
        // deliberately not looked at.
        S_LAUNCH: begin
          dec_start <= 1'b0;
`ifdef SECARB_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (dec_found) begin
            rsp_n     <= dec_n;
            rsp_id    <= grant_reg;
`ifdef SECARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            rsp_valid <= 1'b1;
            state_reg <= S_RESP;
          end
`ifdef SECARB_TIMEOUT_EN
          // A real result takes priority over the watchdog in the same cycle.
          else if (wait_cnt_reg == CNT_W'(MAX_WAIT-1)) begin
            rsp_n     <= '1;
            rsp_id    <= grant_reg;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_reg <= S_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end

        // The response stays frozen until it is taken. The next grant is
        // possible only from IDLE, one cycle after the handshake.
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            rr_ptr_reg <= grant_reg;
            state_reg  <= S_IDLE;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
